// File: rtl/spi_read_engine_if.sv
// Command/response link between the register block (master) and the SPI read engine (slave).
interface spi_read_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [1:0]  cmd_len;
  logic        busy;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready, busy, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready, busy, rd_data, rd_valid
  );
endinterface

// File: rtl/spi_read_engine.sv
// SPI mode-0 read engine: shifts out {opcode, addr}, then shifts in 1-4 bytes,
// returning them right-justified with a one-cycle rd_valid strobe.
module spi_read_engine #(
  parameter int unsigned CLK_DIV     = 4,
  parameter logic [7:0]  READ_OPCODE = 8'h03
) (
  input  logic        clock,
  input  logic        reset,
  spi_read_engine_if.slave cmd,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_read_engine: CLK_DIV must be within 2..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  nbits_q, nbits_d;
  logic [15:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic [5:0]  k_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      nbits_q    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      nbits_q    <= nbits_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    nbits_d    = nbits_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    k_nxt      = k_q + 6'd1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = S_CS_SETUP;
          cnt_d   = '0;
          k_d     = '0;
          tx_d    = {READ_OPCODE, cmd.cmd_addr};
          nbits_d = 6'd24 + {1'b0, cmd.cmd_len, 3'b000};
          rx_d    = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = READ_OPCODE[7];
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: the first 16 bits are command bits, nothing to capture.
            sclk_d = 1'b1;
            if (k_q >= 6'd16) rx_d = {rx_q[30:0], spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (k_q == nbits_q - 6'd1) begin
              state_d = S_CS_HOLD;
              mosi_d  = 1'b0;
            end else begin
              k_d    = k_nxt;
              mosi_d = (k_nxt < 6'd16) ? tx_q[4'd15 - k_nxt[3:0]] : 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          state_d    = S_DONE;
          cs_n_d     = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = rx_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.busy      = (state_q != S_IDLE);
  assign cmd.rd_data   = rd_data_q;
  assign cmd.rd_valid  = rd_valid_q;
  assign spi_sclk      = sclk_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_read_engine.sv
// Directed bench: two engines (CLK_DIV 4 and 2) with a mode-0 slave model and bus monitor.
module tb_spi_read_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_read_engine_if if0 ();
  spi_read_engine_if if1 ();
  logic [1:0] sclk, cs_n, mosi;
  logic [1:0] miso = 2'b00;

  spi_read_engine #(.CLK_DIV(4), .READ_OPCODE(8'h03)) u_div4 (
    .clock(clk), .reset(rst), .cmd(if0.slave),
    .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

  spi_read_engine #(.CLK_DIV(2), .READ_OPCODE(8'h03)) u_div2 (
    .clock(clk), .reset(rst), .cmd(if1.slave),
    .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

  int total = 0;
  int bad   = 0;

  // Monitor / slave state, one slot per engine.
  int          cyc = 0;
  logic [1:0]  p_sclk = 2'b00, p_cs = 2'b11, p_vld = 2'b00;
  logic [1:0]  vld_cs_hi = 2'b00, rdy_in_vld = 2'b00, rdy_after = 2'b00;
  int          rise_cnt[2], cs_low[2], last_cs_low[2], hi_run[2], last_gap[2];
  int          vld_cnt[2], fall_cnt[2], last_rise[2], last_period[2], last_high[2];
  logic [47:0] mosi_sh[2], pat[2];
  logic [31:0] last_data[2];

  initial begin
    for (int g = 0; g < 2; g++) begin
      rise_cnt[g] = 0; cs_low[g] = 0; last_cs_low[g] = 0; hi_run[g] = 0; last_gap[g] = 0;
      vld_cnt[g] = 0; fall_cnt[g] = 0; last_rise[g] = 0; last_period[g] = 0; last_high[g] = 0;
      mosi_sh[g] = '0; pat[g] = '0; last_data[g] = '0;
    end
  end

  task automatic mon(input int g, input logic s, input logic c, input logic m,
                     input logic v, input logic [31:0] d, input logic r);
    if (!c && p_cs[g]) begin
      fall_cnt[g]++; cs_low[g] = 1; last_gap[g] = hi_run[g]; rise_cnt[g] = 0; mosi_sh[g] = '0;
    end else if (!c) cs_low[g]++;
    if (c && !p_cs[g]) begin
      last_cs_low[g] = cs_low[g]; hi_run[g] = 1;
    end else if (c) hi_run[g]++;
    if (s && !p_sclk[g]) begin
      if (rise_cnt[g] > 0) last_period[g] = cyc - last_rise[g];
      last_rise[g] = cyc;
      mosi_sh[g]   = {mosi_sh[g][46:0], m};
      rise_cnt[g]++;
    end
    if (!s && p_sclk[g]) last_high[g] = cyc - last_rise[g];
    // Slave shifts its next bit out after each rising edge (mode 0).
    miso[g] = (rise_cnt[g] < 48) ? pat[g][47 - rise_cnt[g]] : 1'b0;
    if (p_vld[g]) rdy_after[g] = r;
    if (v) begin
      vld_cnt[g]++; last_data[g] = d; vld_cs_hi[g] = c; rdy_in_vld[g] = r;
    end
    p_sclk[g] = s; p_cs[g] = c; p_vld[g] = v;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, sclk[0], cs_n[0], mosi[0], if0.rd_valid, if0.rd_data, if0.cmd_ready);
    mon(1, sclk[1], cs_n[1], mosi[1], if1.rd_valid, if1.rd_data, if1.cmd_ready);
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int g, input logic [7:0] a, input logic [1:0] l);
    tick();
    if (g == 0) begin if0.cmd_valid = 1'b1; if0.cmd_addr = a; if0.cmd_len = l; end
    else        begin if1.cmd_valid = 1'b1; if1.cmd_addr = a; if1.cmd_len = l; end
    tick();
    // Scramble the command right after accept; the engine must have latched it.
    if (g == 0) begin if0.cmd_valid = 1'b0; if0.cmd_addr = 8'hFF; if0.cmd_len = 2'd2; end
    else        begin if1.cmd_valid = 1'b0; if1.cmd_addr = 8'hFF; if1.cmd_len = 2'd2; end
  endtask

  task automatic wait_vld(input int g, input int target, input string tag);
    int n = 0;
    while (vld_cnt[g] < target && n < 3000) begin tick(); n++; end
    check(tag, 48'(vld_cnt[g] >= target), 48'd1);
  endtask

  initial begin
    int r;
    int n;
    if0.cmd_valid = 1'b1; if0.cmd_addr = 8'h00; if0.cmd_len = 2'd0;
    if1.cmd_valid = 1'b0; if1.cmd_addr = 8'h00; if1.cmd_len = 2'd0;
    repeat (3) tick();
    check("rst_pins0", 48'({sclk[0], cs_n[0], mosi[0], if0.rd_valid, if0.busy, if0.cmd_ready}), 48'b010001);
    check("rst_pins1", 48'({sclk[1], cs_n[1], mosi[1], if1.rd_valid, if1.busy, if1.cmd_ready}), 48'b010001);
    check("rst_data0", 48'(if0.rd_data), 48'h0);
    check("rst_nocmd", 48'(fall_cnt[0]), 48'd0);
    if0.cmd_valid = 1'b0;
    rst = 1'b0;

    // Single byte, plus a cmd_valid pulse while busy.
    pat[0] = {16'h0, 32'hA500_0000};
    send(0, 8'h12, 2'd0);
    repeat (20) tick();
    check("busy_mid", 48'({if0.busy, if0.cmd_ready}), 48'b10);
    if0.cmd_valid = 1'b1; if0.cmd_addr = 8'h77;
    tick();
    if0.cmd_valid = 1'b0;
    wait_vld(0, 1, "t1_timeout");
    check("t1_data",   48'(last_data[0]), 48'h0000_00A5);
    check("t1_rises",  48'(rise_cnt[0]), 48'd24);
    check("t1_mosi",   mosi_sh[0], 48'h03_1200);
    check("t1_cslow",  48'(last_cs_low[0]), 48'd200);
    check("t1_period", 48'(last_period[0]), 48'd8);
    check("t1_high",   48'(last_high[0]), 48'd4);
    check("t1_vld_cs", 48'({vld_cs_hi[0], rdy_in_vld[0]}), 48'b10);
    repeat (5) tick();
    check("t1_rdy_after", 48'(rdy_after[0]), 48'd1);
    check("t1_one_txn",   48'(fall_cnt[0]), 48'd1);
    check("t1_one_vld",   48'(vld_cnt[0]), 48'd1);

    // Full word.
    pat[0] = {16'h0, 32'hDEAD_BEEF};
    send(0, 8'h34, 2'd3);
    wait_vld(0, 2, "t2_timeout");
    check("t2_data",  48'(last_data[0]), 48'hDEAD_BEEF);
    check("t2_rises", 48'(rise_cnt[0]), 48'd48);
    check("t2_mosi",  mosi_sh[0], {16'h0334, 32'h0});
    check("t2_cslow", 48'(last_cs_low[0]), 48'd392);
    repeat (3) tick();

    // Back-to-back with cmd_valid held high.
    pat[0] = {16'h0, 32'h1122_0000};
    if0.cmd_valid = 1'b1; if0.cmd_addr = 8'h56; if0.cmd_len = 2'd1;
    tick();
    if0.cmd_addr = 8'h9A; if0.cmd_len = 2'd0;
    wait_vld(0, 3, "t3a_timeout");
    pat[0] = {16'h0, 32'h3300_0000};
    check("t3a_data",  48'(last_data[0]), 48'h0000_1122);
    check("t3a_cslow", 48'(last_cs_low[0]), 48'd264);
    tick();
    if0.cmd_valid = 1'b0;
    wait_vld(0, 4, "t3b_timeout");
    check("t3b_data",  48'(last_data[0]), 48'h0000_0033);
    check("t3b_gap",   48'(last_gap[0]), 48'd2);
    check("t3b_mosi",  mosi_sh[0], 48'h03_9A00);
    check("t3b_falls", 48'(fall_cnt[0]), 48'd4);

    // Divider corner on the CLK_DIV=2 engine.
    pat[1] = {16'h0, 32'hC35A_0000};
    send(1, 8'hAB, 2'd1);
    wait_vld(1, 1, "t4_timeout");
    check("t4_data",   48'(last_data[1]), 48'h0000_C35A);
    check("t4_rises",  48'(rise_cnt[1]), 48'd32);
    check("t4_mosi",   mosi_sh[1], {16'h0, 16'h03AB, 16'h0});
    check("t4_cslow",  48'(last_cs_low[1]), 48'd132);
    check("t4_period", 48'(last_period[1]), 48'd4);
    check("t4_high",   48'(last_high[1]), 48'd2);

    // Reset in the middle of the data phase.
    repeat (3) tick();
    pat[0] = {16'h0, 32'hDEAD_BEEF};
    send(0, 8'h55, 2'd3);
    n = 0;
    while (rise_cnt[0] < 21 && n < 2000) begin tick(); n++; end
    check("t5_reach_bit20", 48'(rise_cnt[0] >= 21), 48'd1);
    rst = 1'b1;
    tick();
    check("t5_pins", 48'({sclk[0], cs_n[0], mosi[0], if0.rd_valid}), 48'b0100);
    check("t5_data", 48'(if0.rd_data), 48'h0);
    r = rise_cnt[0];
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("t5_idle",    48'({if0.cmd_ready, if0.busy, cs_n[0]}), 48'b101);
    check("t5_no_vld",  48'(vld_cnt[0]), 48'd4);
    check("t5_no_rise", 48'(rise_cnt[0]), 48'(r));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
